// File: rtl/mips_seq_alu_if.sv
// Request/result bundle for the sequential MIPS ALU.
// master issues start/ctl/a/b; slave returns registered results.
interface mips_seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             valid;
  logic             busy;
  logic             div_zero;

  modport master (
    output start, ctl, a, b,
    input  out, hi, zero, valid, busy, div_zero
  );

  modport slave (
    input  start, ctl, a, b,
    output out, hi, zero, valid, busy, div_zero
  );
endinterface

// File: rtl/mips_seq_alu.sv
// Registered MIPS ALU with bit-serial MULTU/DIVU.
// Single-cycle ops answer next cycle; MULTU/DIVU take WIDTH cycles.
module mips_seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic clk,
  input  logic rst_n,
  mips_seq_alu_if.slave bus
);

  localparam logic [3:0] C_AND  = 4'd0;
  localparam logic [3:0] C_OR   = 4'd1;
  localparam logic [3:0] C_ADD  = 4'd2;
  localparam logic [3:0] C_DIVU = 4'd3;
  localparam logic [3:0] C_MULT = 4'd4;
  localparam logic [3:0] C_SUB  = 4'd6;
  localparam logic [3:0] C_SLTU = 4'd7;
  localparam logic [3:0] C_NOR  = 4'd12;

  typedef enum logic {IDLE, ITER} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic             isdiv_q, isdiv_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] alu;
  logic [WIDTH-1:0] s_acc, s_lo, s_op;
  logic             s_div;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   dt;
  logic [WIDTH-1:0] st_acc, st_lo;
  logic             iter_req;

  always_comb begin
    unique case (bus.ctl)
      C_AND:   alu = bus.a & bus.b;
      C_OR:    alu = bus.a | bus.b;
      C_ADD:   alu = bus.a + bus.b;
      C_SUB:   alu = bus.a - bus.b;
      C_SLTU:  alu = WIDTH'(bus.a < bus.b);
      C_NOR:   alu = ~(bus.a | bus.b);
      default: alu = '0;
    endcase
  end

  // The accepting edge already performs the first step on fresh operands,
  // so the last of WIDTH steps lands WIDTH cycles after the start cycle.
  always_comb begin
    if (state_q == IDLE) begin
      s_div = (bus.ctl == C_DIVU);
      s_acc = '0;
      s_lo  = s_div ? bus.a : bus.b;
      s_op  = s_div ? bus.b : bus.a;
    end else begin
      s_div = isdiv_q;
      s_acc = acc_q;
      s_lo  = lo_q;
      s_op  = op_q;
    end
    msum = {1'b0, s_acc} + (s_lo[0] ? {1'b0, s_op} : '0);
    dt   = {s_acc, s_lo[WIDTH-1]};
    if (s_div) begin
      if (dt >= {1'b0, s_op}) begin
        st_acc = dt[WIDTH-1:0] - s_op;
        st_lo  = {s_lo[WIDTH-2:0], 1'b1};
      end else begin
        st_acc = dt[WIDTH-1:0];
        st_lo  = {s_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      st_acc = msum[WIDTH:1];
      st_lo  = {msum[0], s_lo[WIDTH-1:1]};
    end
  end

  assign iter_req = (bus.ctl == C_MULT) ||
                    ((bus.ctl == C_DIVU) && (bus.b != '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    op_d    = op_q;
    isdiv_d = isdiv_q;
    out_d   = out_q;
    hi_d    = hi_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (iter_req) begin
            acc_d   = st_acc;
            lo_d    = st_lo;
            op_d    = s_op;
            isdiv_d = s_div;
            cnt_d   = CNT_W'(WIDTH - 1);
            busy_d  = 1'b1;
            state_d = ITER;
          end else if (bus.ctl == C_DIVU) begin
            out_d   = '1;
            hi_d    = bus.a;
            dz_d    = 1'b1;
            valid_d = 1'b1;
          end else begin
            out_d   = alu;
            dz_d    = 1'b0;
            valid_d = 1'b1;
          end
        end
      end
      ITER: begin
        acc_d = st_acc;
        lo_d  = st_lo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          out_d   = st_lo;
          hi_d    = st_acc;
          dz_d    = 1'b0;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      isdiv_q <= 1'b0;
      out_q   <= '0;
      hi_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      isdiv_q <= isdiv_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.out      = out_q;
  assign bus.hi       = hi_q;
  assign bus.zero     = (out_q == '0);
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.div_zero = dz_q;

endmodule
